// File: rtl/apu_note_sequencer.sv
// Pattern sequencer for the sine-PWM voice: steps a flop-based pattern RAM at a programmable
// tempo and owns the voice divider and gate.
//
// state | meaning
// IDLE  | stopped; gate off, divider held
// LOAD  | one clock: latch pattern[step_idx] into the note registers
// NOTE  | gate follows ~rest for (len+1) ticks
// GAP   | gate off for one tick, then advance, wrap or finish
module apu_note_sequencer #(
  parameter  int STEPS  = 16,
  parameter  int DIV_W  = 12,
  parameter  int LEN_W  = 4,
  parameter  int TICK_W = 20,
  localparam int AW     = $clog2(STEPS),
  localparam int ENT_W  = 1 + LEN_W + DIV_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en_i,
  input  logic [TICK_W-1:0] tempo_i,
  input  logic [AW-1:0]     last_step_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [ENT_W-1:0]  wr_data_i,
  output logic [DIV_W-1:0]  divider_o,
  output logic              voice_en_o,
  output logic              busy_o,
  output logic [AW-1:0]     step_idx_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [ENT_W-1:0]    pat_q [STEPS];
  logic [ENT_W-1:0]    entry;
  logic [DIV_W-1:0]    divider_q, divider_d;
  logic                voice_en_q, voice_en_d;
  logic                done_q, done_d;
  logic [AW-1:0]       step_q, step_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [LEN_W-1:0]    ticks_q, ticks_d;
  logic                tick;
  logic                last_hit;
  logic                stop_act;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STEPS; i++) pat_q[i] <= '0;
    end else if (wr_en_i) begin
      pat_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign entry    = pat_q[step_q];
  // >= rather than == so a tempo lowered below the running count still ticks at once.
  assign tick     = ((state_q == S_NOTE) || (state_q == S_GAP)) && (presc_q >= tempo_i);
  assign last_hit = (step_q == last_step_i);
  assign stop_act = stop_i && (state_q != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i && !stop_i) state_d = S_LOAD;
        S_LOAD: state_d = S_NOTE;
        S_NOTE: if (tick && (ticks_q == '0)) state_d = S_GAP;
        S_GAP: begin
          if (tick) begin
            if (last_hit && !loop_en_i) state_d = S_IDLE;
            else                        state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    divider_d  = divider_q;
    voice_en_d = voice_en_q;
    done_d     = 1'b0;
    step_d     = step_q;
    presc_d    = presc_q;
    ticks_d    = ticks_q;
    if (stop_act) begin
      voice_en_d = 1'b0;
      presc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          voice_en_d = 1'b0;
          presc_d    = '0;
          if (start_i && !stop_i) step_d = '0;
        end
        S_LOAD: begin
          divider_d  = entry[DIV_W-1:0];
          voice_en_d = ~entry[ENT_W-1];
          ticks_d    = entry[DIV_W +: LEN_W];
          presc_d    = '0;
        end
        S_NOTE: begin
          if (tick) begin
            presc_d = '0;
            if (ticks_q == '0) voice_en_d = 1'b0;
            else               ticks_d    = ticks_q - LEN_W'(1);
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
        end
        S_GAP: begin
          if (tick) begin
            presc_d = '0;
            if (last_hit) begin
              if (loop_en_i) step_d = '0;
              else           done_d = 1'b1;
            end else begin
              step_d = step_q + AW'(1);
            end
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      divider_q  <= '0;
      voice_en_q <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      presc_q    <= '0;
      ticks_q    <= '0;
    end else begin
      divider_q  <= divider_d;
      voice_en_q <= voice_en_d;
      done_q     <= done_d;
      step_q     <= step_d;
      presc_q    <= presc_d;
      ticks_q    <= ticks_d;
    end
  end

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    divider_o  = divider_q;
    voice_en_o = voice_en_q;
    step_idx_o = step_q;
    done_o     = done_q;
  end

endmodule

// File: tb/tb_apu_note_sequencer.sv
// Scoreboard bench for apu_note_sequencer: a timeline model expands each play into per-clock
// expected outputs; a negedge monitor pops and compares them.
module tb_apu_note_sequencer;
  localparam int STEPS  = 16;
  localparam int DIV_W  = 12;
  localparam int LEN_W  = 4;
  localparam int TICK_W = 20;
  localparam int AW     = 4;
  localparam int ENT_W  = 1 + LEN_W + DIV_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              loop_en_i = 1'b0;
  logic [TICK_W-1:0] tempo_i = '0;
  logic [AW-1:0]     last_step_i = '0;
  logic              wr_en_i = 1'b0;
  logic [AW-1:0]     wr_addr_i = '0;
  logic [ENT_W-1:0]  wr_data_i = '0;
  logic [DIV_W-1:0]  divider_o;
  logic              voice_en_o;
  logic              busy_o;
  logic [AW-1:0]     step_idx_o;
  logic              done_o;

  apu_note_sequencer #(.STEPS(STEPS), .DIV_W(DIV_W), .LEN_W(LEN_W), .TICK_W(TICK_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .loop_en_i(loop_en_i),
    .tempo_i(tempo_i), .last_step_i(last_step_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .divider_o(divider_o), .voice_en_o(voice_en_o), .busy_o(busy_o),
    .step_idx_o(step_idx_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             ven;
    logic             busy;
    logic [AW-1:0]    step;
    logic             done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Shadow of the pattern RAM and of the held output registers.
  logic [DIV_W-1:0] m_div  [STEPS];
  int               m_len  [STEPS];
  bit               m_rest [STEPS];
  logic [DIV_W-1:0] cur_div = '0;
  logic [AW-1:0]    cur_step = '0;

  exp_t mon_e, mon_a;
  always @(negedge clk_i) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {divider_o, voice_en_o, busy_o, step_idx_o, done_o};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL sample t=%0t got div=%0d ven=%0b busy=%0b step=%0d done=%0b, expected div=%0d ven=%0b busy=%0b step=%0d done=%0b",
                 $time, mon_a.div, mon_a.ven, mon_a.busy, mon_a.step, mon_a.done,
                 mon_e.div, mon_e.ven, mon_e.busy, mon_e.step, mon_e.done);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [DIV_W-1:0] d, input logic v, input logic b,
                              input int s, input logic dn);
    exp_t e;
    e.div = d; e.ven = v; e.busy = b; e.step = AW'(s); e.done = dn;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expand a play into one expected sample per clock, starting with the LOAD cycle.
  // Each step: 1 LOAD clock, (len+1)*(tempo+1) NOTE clocks, (tempo+1) GAP clocks.
  task automatic build(input int stop_at, output int n_tot, output int n_busy);
    exp_t tl[$];
    exp_t e;
    int s = 0;
    int nn, ng;
    bit fin = 0;
    logic [DIV_W-1:0] d = cur_div;
    ng = int'(tempo_i) + 1;
    while (!fin) begin
      tl.push_back(mk(d, 1'b0, 1'b1, s, 1'b0));
      nn = (m_len[s] + 1) * ng;
      d = m_div[s];
      repeat (nn) tl.push_back(mk(d, !m_rest[s], 1'b1, s, 1'b0));
      repeat (ng) tl.push_back(mk(d, 1'b0, 1'b1, s, 1'b0));
      if (stop_at >= 0 && tl.size() > stop_at) fin = 1;
      else if (s == int'(last_step_i)) begin
        if (loop_en_i) s = 0;
        else fin = 1;
      end else s++;
      if (tl.size() > 20000) fin = 1;
    end
    if (stop_at >= 0 && tl.size() > stop_at) begin
      e = tl[stop_at];
      while (tl.size() > stop_at + 1) void'(tl.pop_back());
      n_busy = tl.size();
      tl.push_back(mk(e.div, 1'b0, 1'b0, int'(e.step), 1'b0));
      tl.push_back(mk(e.div, 1'b0, 1'b0, int'(e.step), 1'b0));
    end else begin
      n_busy = tl.size();
      e = tl[tl.size()-1];
      tl.push_back(mk(e.div, 1'b0, 1'b0, int'(e.step), 1'b1));
      tl.push_back(mk(e.div, 1'b0, 1'b0, int'(e.step), 1'b0));
    end
    cur_div  = tl[tl.size()-1].div;
    cur_step = tl[tl.size()-1].step;
    n_tot = tl.size();
    foreach (tl[i]) sb_q.push_back(tl[i]);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d samples left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wr(input int a, input logic [DIV_W-1:0] d, input int len, input bit rest);
    @(posedge clk_i); #1;
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(a);
    wr_data_i = {rest, LEN_W'(len), d};
    @(posedge clk_i); #1;
    wr_en_i   = 1'b0;
    m_div[a] = d; m_len[a] = len; m_rest[a] = rest;
  endtask

  // stop_at / xstart are sample indices (0 = LOAD cycle) during which stop/start is held high.
  task automatic play(input int stop_at, input int xstart);
    int n_tot, n_busy;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    build(stop_at, n_tot, n_busy);
    for (int c = 0; c < n_tot; c++) begin
      stop_i  = (c == stop_at) && (c < n_busy);
      start_i = (c == xstart) && (c < n_busy);
      @(posedge clk_i); #1;
    end
    stop_i  = 1'b0;
    start_i = 1'b0;
    drain();
  endtask

  initial begin
    int n_tot, n_busy, sa, xs, nst;
    for (int i = 0; i < STEPS; i++) begin
      m_div[i] = '0; m_len[i] = 0; m_rest[i] = 1'b0;
    end
    #7;
    chk("rst_divider",  32'(divider_o),  32'd0);
    chk("rst_voice_en", 32'(voice_en_o), 32'd0);
    chk("rst_busy",     32'(busy_o),     32'd0);
    chk("rst_step_idx", 32'(step_idx_o), 32'd0);
    chk("rst_done",     32'(done_o),     32'd0);
    @(negedge clk_i) rst_i = 1'b0;

    // Three gated notes, 13-clock step period, one done pulse.
    wr(0, 12'd10, 1, 1'b0);
    wr(1, 12'd20, 1, 1'b0);
    wr(2, 12'd30, 1, 1'b0);
    tempo_i = 20'd3; last_step_i = 4'd2; loop_en_i = 1'b0;
    play(-1, -1);

    // Looping: steps 0,1,2,0,1 then stop mid-note of the second pass through step 1.
    loop_en_i = 1'b1;
    play(56, -1);

    // Step 1 as a rest: gate stays low, divider still moves to 20.
    loop_en_i = 1'b0;
    wr(1, 12'd20, 1, 1'b1);
    play(-1, -1);

    // Start while busy is ignored.
    play(-1, 20);

    // Start and stop together in IDLE: stays idle.
    @(posedge clk_i); #1 start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0; stop_i = 1'b0;
    repeat (3) sb_q.push_back(mk(cur_div, 1'b0, 1'b0, int'(cur_step), 1'b0));
    repeat (3) begin @(posedge clk_i); #1; end
    drain();

    // Tempo lowered 1000 -> 2 while the prescaler sits at 500.
    wr(0, 12'h5A5, 1, 1'b0);
    last_step_i = 4'd0; loop_en_i = 1'b0; tempo_i = 20'd1000;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    sb_q.push_back(mk(cur_div, 1'b0, 1'b1, 0, 1'b0));
    repeat (504) sb_q.push_back(mk(12'h5A5, 1'b1, 1'b1, 0, 1'b0));
    repeat (3)   sb_q.push_back(mk(12'h5A5, 1'b0, 1'b1, 0, 1'b0));
    sb_q.push_back(mk(12'h5A5, 1'b0, 1'b0, 0, 1'b1));
    sb_q.push_back(mk(12'h5A5, 1'b0, 1'b0, 0, 1'b0));
    cur_div = 12'h5A5; cur_step = '0;
    for (int c = 0; c < 510; c++) begin
      if (c == 501) tempo_i = 20'd2;
      @(posedge clk_i); #1;
    end
    drain();

    // Randomized patterns, tempos, loop modes, stops and stray starts.
    repeat (30) begin
      nst = $urandom_range(1, 6);
      for (int i = 0; i < nst; i++)
        if ($urandom_range(0, 3) != 0)
          wr(i, DIV_W'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      tempo_i     = TICK_W'($urandom_range(0, 4));
      last_step_i = AW'(nst - 1);
      loop_en_i   = 1'($urandom_range(0, 1));
      if (loop_en_i) sa = $urandom_range(0, 150);
      else if ($urandom_range(0, 2) == 0) sa = $urandom_range(0, 120);
      else sa = -1;
      if ($urandom_range(0, 3) == 0) xs = $urandom_range(0, 100);
      else xs = -1;
      play(sa, xs);
    end

    // Reset during NOTE clears outputs at once and wipes the pattern RAM.
    wr(0, 12'd100, 3, 1'b0);
    wr(1, 12'd200, 3, 1'b0);
    tempo_i = 20'd2; last_step_i = 4'd1; loop_en_i = 1'b0;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    build(-1, n_tot, n_busy);
    repeat (6) begin @(posedge clk_i); #1; end
    sb_q.delete();
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_divider",  32'(divider_o),  32'd0);
    chk("midrst_voice_en", 32'(voice_en_o), 32'd0);
    chk("midrst_busy",     32'(busy_o),     32'd0);
    chk("midrst_step_idx", 32'(step_idx_o), 32'd0);
    chk("midrst_done",     32'(done_o),     32'd0);
    @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      m_div[i] = '0; m_len[i] = 0; m_rest[i] = 1'b0;
    end
    cur_div = '0; cur_step = '0;
    tempo_i = 20'd1; last_step_i = 4'd0; loop_en_i = 1'b0;
    play(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
